// File: rtl/add_slice_sched_pkg.sv
// Shared constants and types for the shared 8-bit adder slice scheduler.
//  SLICE_W   : slice width (only 8 is supported)
//  WIDE_W    : width of a wide (two-pass) operation
//  ID_W      : requester index width
//  ST_*      : 2-bit FSM state encodings
//  req_op_t  : captured operation payload (A, B', sub, wide)
package add_slice_sched_pkg;

  localparam int unsigned SLICE_W = 8;
  localparam int unsigned WIDE_W  = 2 * SLICE_W;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_LO   = 2'd1;
  localparam logic [STATE_W-1:0] ST_HI   = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [WIDE_W-1:0] a;
    logic [WIDE_W-1:0] b_eff;
    logic              sub;
    logic              wide;
  } req_op_t;

  // Subtraction is A + ~B + 1; the +1 enters as the low-slice carry-in.
  function automatic logic [WIDE_W-1:0] b_operand(input logic [WIDE_W-1:0] b,
                                                  input logic              sub);
    return sub ? ~b : b;
  endfunction

endpackage

// File: rtl/add_slice_sched_add8_cin.sv
// add8_cin: combinational 8-bit adder slice with carry in/out.
//  a, b : slice operands
//  cin  : carry in
//  sum  : slice sum
//  cout : carry out of the slice
module add8_cin
  import add_slice_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] full;

  assign full = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);
  assign sum  = full[SLICE_W-1:0];
  assign cout = full[SLICE_W];

endmodule

// File: rtl/add_slice_sched.sv
// add_slice_sched: shares one 8-bit adder slice between two requesters.
// Round-robin arbitration in IDLE, then one slice pass (narrow) or two passes
// (wide, low byte first with carry chained) and a registered response.
//  clk, rst_n          : clock, async active-low reset
//  req_valid/req_ready : per-requester handshake (req_ready combinational)
//  req{0,1}_A/_B       : 16-bit operands
//  req{0,1}_sub/_wide  : subtract select, 16-bit select
//  resp_valid/ready    : result handshake
//  resp_id, resp_sum, resp_cout, resp_pos_ovfl, resp_neg_ovfl, resp_ovfl : result
//  busy                : FSM not in IDLE
module add_slice_sched
  import add_slice_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [WIDE_W-1:0]   req0_A,
  input  logic [WIDE_W-1:0]   req0_B,
  input  logic                req0_sub,
  input  logic                req0_wide,
  input  logic [WIDE_W-1:0]   req1_A,
  input  logic [WIDE_W-1:0]   req1_B,
  input  logic                req1_sub,
  input  logic                req1_wide,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [WIDE_W-1:0]   resp_sum,
  output logic                resp_cout,
  output logic                resp_pos_ovfl,
  output logic                resp_neg_ovfl,
  output logic                resp_ovfl,
  output logic                busy
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_id_c;
  logic               accept_c;
  logic [ID_W-1:0]    last_grant_q;

  req_op_t            pick_c;
  req_op_t            op_q;
  logic [ID_W-1:0]    id_q;

  logic [SLICE_W-1:0] sum_lo_q;
  logic               carry_lo_q;

  logic [SLICE_W-1:0] slice_a_c;
  logic [SLICE_W-1:0] slice_b_c;
  logic               slice_cin_c;
  logic [SLICE_W-1:0] slice_sum_c;
  logic               slice_cout_c;
  logic               pos_ovfl_c;
  logic               neg_ovfl_c;

  // Round-robin arbiter: on contention the requester that did not win last time.
  always_comb begin
    grant_c = '0;
    if (req_valid == 2'b11) begin
      grant_c = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      grant_c = req_valid;
    end
  end

  assign grant_id_c = ID_W'(grant_c[1]);
  assign req_ready  = (state_q == ST_IDLE) ? grant_c : '0;
  assign accept_c   = |(req_valid & req_ready);

  // Payload of the granted requester, B already conditioned for subtraction.
  always_comb begin
    pick_c = '0;
    if (grant_c[1]) begin
      pick_c.a     = req1_A;
      pick_c.b_eff = b_operand(req1_B, req1_sub);
      pick_c.sub   = req1_sub;
      pick_c.wide  = req1_wide;
    end else begin
      pick_c.a     = req0_A;
      pick_c.b_eff = b_operand(req0_B, req0_sub);
      pick_c.sub   = req0_sub;
      pick_c.wide  = req0_wide;
    end
  end

  // Slice input mux: high byte with chained carry in HI, low byte otherwise.
  always_comb begin
    slice_a_c   = op_q.a[SLICE_W-1:0];
    slice_b_c   = op_q.b_eff[SLICE_W-1:0];
    slice_cin_c = op_q.sub;
    if (state_q == ST_HI) begin
      slice_a_c   = op_q.a[WIDE_W-1:SLICE_W];
      slice_b_c   = op_q.b_eff[WIDE_W-1:SLICE_W];
      slice_cin_c = carry_lo_q;
    end
  end

  add8_cin u_slice (
    .a    (slice_a_c),
    .b    (slice_b_c),
    .cin  (slice_cin_c),
    .sum  (slice_sum_c),
    .cout (slice_cout_c)
  );

  // Signed overflow from the msb of whichever slice pass is the top byte.
  assign pos_ovfl_c = ~slice_a_c[SLICE_W-1] & ~slice_b_c[SLICE_W-1] &  slice_sum_c[SLICE_W-1];
  assign neg_ovfl_c =  slice_a_c[SLICE_W-1] &  slice_b_c[SLICE_W-1] & ~slice_sum_c[SLICE_W-1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)   state_d = ST_LO;
      ST_LO:   state_d = op_q.wide ? ST_HI : ST_DONE;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      busy       <= (state_d != ST_IDLE);
      resp_valid <= (state_d == ST_DONE);
    end
  end

  // Operand capture and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(1);
    end else if (accept_c) begin
      op_q         <= pick_c;
      id_q         <= grant_id_c;
      last_grant_q <= grant_id_c;
    end
  end

  // Slice results: low pass always, top pass writes the response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_lo_q      <= '0;
      carry_lo_q    <= 1'b0;
      resp_id       <= '0;
      resp_sum      <= '0;
      resp_cout     <= 1'b0;
      resp_pos_ovfl <= 1'b0;
      resp_neg_ovfl <= 1'b0;
      resp_ovfl     <= 1'b0;
    end else begin
      if (state_q == ST_LO) begin
        sum_lo_q   <= slice_sum_c;
        carry_lo_q <= slice_cout_c;
      end
      if ((state_q == ST_LO && !op_q.wide) || state_q == ST_HI) begin
        resp_id       <= id_q;
        resp_cout     <= slice_cout_c;
        resp_pos_ovfl <= pos_ovfl_c;
        resp_neg_ovfl <= neg_ovfl_c;
        resp_ovfl     <= pos_ovfl_c | neg_ovfl_c;
        resp_sum      <= (state_q == ST_HI) ? {slice_sum_c, sum_lo_q}
                                            : {SLICE_W'(0), slice_sum_c};
      end
    end
  end

endmodule

// File: tb/tb_add_slice_sched.sv
// Directed self-checking bench for add_slice_sched.
module tb_add_slice_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_A, req0_B, req1_A, req1_B;
  logic        req0_sub, req0_wide, req1_sub, req1_wide;
  logic        resp_valid, resp_ready;
  logic [0:0]  resp_id;
  logic [15:0] resp_sum;
  logic        resp_cout, resp_pos_ovfl, resp_neg_ovfl, resp_ovfl, busy;

  int total = 0;
  int bad   = 0;

  add_slice_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_sub(req0_sub), .req0_wide(req0_wide),
    .req1_A(req1_A), .req1_B(req1_B), .req1_sub(req1_sub), .req1_wide(req1_wide),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_pos_ovfl(resp_pos_ovfl),
    .resp_neg_ovfl(resp_neg_ovfl), .resp_ovfl(resp_ovfl), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge, hold it over one edge, then drop it.
  task automatic send(input int id, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic wide);
    @(negedge clk);
    if (id == 0) begin
      req0_A = a; req0_B = b; req0_sub = sub; req0_wide = wide; req_valid = 2'b01;
    end else begin
      req1_A = a; req1_B = b; req1_sub = sub; req1_wide = wide; req_valid = 2'b10;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  // Count negedges until resp_valid (bounded).
  task automatic wait_resp(output int cycles);
    cycles = 0;
    while (resp_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    req0_A = '0; req0_B = '0; req0_sub = 0; req0_wide = 0;
    req1_A = '0; req1_B = '0; req1_sub = 0; req1_wide = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, busy, req_ready} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {resp_valid, busy, req_ready});
    end
    total++;
    if ({resp_id, resp_sum, resp_cout, resp_pos_ovfl, resp_neg_ovfl, resp_ovfl} !== 21'd0) begin
      bad++; $display("FAIL reset_resp got sum=%h id=%b", resp_sum, resp_id);
    end
    rst_n = 1'b1;
  endtask

  // Narrow add on requester 0 with exact latency check.
  task automatic test_narrow_add();
    @(negedge clk);
    req0_A = 16'h0050; req0_B = 16'h0030; req0_sub = 0; req0_wide = 0; req_valid = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL t1_ready got=%b exp=01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL t1_early got=%b exp=0", resp_valid); end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_sum !== 16'h0080 || resp_id !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL t1_resp got v=%b sum=%h id=%b busy=%b exp v=1 sum=0080 id=0 busy=1",
                      resp_valid, resp_sum, resp_id, busy);
    end
    total++;
    if ({resp_cout, resp_pos_ovfl, resp_neg_ovfl, resp_ovfl} !== 4'b0101) begin
      bad++; $display("FAIL t1_flags got=%b exp=0101",
                      {resp_cout, resp_pos_ovfl, resp_neg_ovfl, resp_ovfl});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t1_release got v=%b busy=%b exp 0 0", resp_valid, busy);
    end
  endtask

  // Wide subtract on requester 1 with three-edge latency.
  task automatic test_wide_sub();
    send(1, 16'h1000, 16'h0001, 1'b1, 1'b1);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL t2_edge1 got=%b exp=0", resp_valid); end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL t2_edge2 got=%b exp=0", resp_valid); end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_sum !== 16'h0FFF || resp_id !== 1'b1 ||
        resp_cout !== 1'b1 || resp_ovfl !== 1'b0) begin
      bad++; $display("FAIL t2_resp got v=%b sum=%h id=%b c=%b o=%b exp v=1 sum=0fff id=1 c=1 o=0",
                      resp_valid, resp_sum, resp_id, resp_cout, resp_ovfl);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // Contention after reset with resp_ready tied high: grants alternate 0,1,0,1.
  task automatic test_round_robin();
    int ng;
    int nr;
    logic [1:0] prev;
    logic [1:0] exp_rr;
    logic [15:0] exp_sum;
    do_reset();
    req0_A = 16'h0001; req0_B = 16'h0002; req0_sub = 0; req0_wide = 0;
    req1_A = 16'h0010; req1_B = 16'h0020; req1_sub = 0; req1_wide = 0;
    req_valid = 2'b11; resp_ready = 1'b1;
    ng = 0; nr = 0; prev = 2'b00;
    for (int cyc = 0; cyc < 40 && (ng < 4 || nr < 4); cyc++) begin
      #1;
      if (req_ready !== 2'b00) begin
        exp_rr = (ng % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== exp_rr || prev !== 2'b00) begin
          bad++; $display("FAIL t3_grant%0d got=%b prev=%b exp=%b prev=00", ng, req_ready, prev, exp_rr);
        end
        ng++;
      end
      if (resp_valid === 1'b1) begin
        exp_sum = (nr % 2 == 0) ? 16'h0003 : 16'h0030;
        total++;
        if (resp_id !== 1'((nr % 2)) || resp_sum !== exp_sum) begin
          bad++; $display("FAIL t3_resp%0d got id=%b sum=%h exp id=%0d sum=%h",
                          nr, resp_id, resp_sum, nr % 2, exp_sum);
        end
        nr++;
        if (nr == 4) req_valid = 2'b00;
      end
      prev = req_ready;
      @(negedge clk);
    end
    req_valid = 2'b00;
    resp_ready = 1'b0;
    total++;
    if (ng != 4 || nr != 4) begin
      bad++; $display("FAIL t3_count got grants=%0d resps=%0d exp 4 4", ng, nr);
    end
  endtask

  // Wide carry propagation and wrap-around.
  task automatic test_wide_edges();
    int cyc;
    send(0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    wait_resp(cyc);
    total++;
    if (cyc != 2 || resp_sum !== 16'h8000 || resp_pos_ovfl !== 1'b1 ||
        resp_neg_ovfl !== 1'b0 || resp_cout !== 1'b0) begin
      bad++; $display("FAIL t4_7fff got cyc=%0d sum=%h p=%b n=%b c=%b exp 2 8000 1 0 0",
                      cyc, resp_sum, resp_pos_ovfl, resp_neg_ovfl, resp_cout);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    wait_resp(cyc);
    total++;
    if (cyc != 2 || resp_sum !== 16'h0000 || resp_cout !== 1'b1 || resp_ovfl !== 1'b0) begin
      bad++; $display("FAIL t4_ffff got cyc=%0d sum=%h c=%b o=%b exp 2 0000 1 0",
                      cyc, resp_sum, resp_cout, resp_ovfl);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  // Response held under backpressure while new requests are pending.
  task automatic test_backpressure();
    int cyc;
    send(1, 16'h0005, 16'h0003, 1'b1, 1'b0);
    wait_resp(cyc);
    total++;
    if (cyc != 1) begin bad++; $display("FAIL t5_latency got=%0d exp=1", cyc); end
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_sum !== 16'h0002 || resp_cout !== 1'b1 ||
          resp_id !== 1'b1 || resp_ovfl !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        bad++; $display("FAIL t5_hold%0d got v=%b sum=%h c=%b id=%b o=%b rdy=%b busy=%b exp 1 0002 1 1 0 00 1",
                        i, resp_valid, resp_sum, resp_cout, resp_id, resp_ovfl, req_ready, busy);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t5_release got v=%b busy=%b exp 0 0", resp_valid, busy);
    end
  endtask

  // Asynchronous reset during the high pass, then a narrow subtract.
  task automatic test_reset_mid();
    int cyc;
    send(0, 16'h1234, 16'h1111, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL t6_busy_hi got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t6_async got v=%b busy=%b exp 0 0", resp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL t6_discard got v=%b busy=%b exp 0 0", resp_valid, busy);
    end
    send(0, 16'h007F, 16'h0080, 1'b1, 1'b0);
    wait_resp(cyc);
    total++;
    if (cyc != 1 || resp_sum !== 16'h00FF || resp_pos_ovfl !== 1'b1 || resp_neg_ovfl !== 1'b0 ||
        resp_ovfl !== 1'b1 || resp_cout !== 1'b0) begin
      bad++; $display("FAIL t6_sub got cyc=%0d sum=%h p=%b n=%b o=%b c=%b exp 1 00ff 1 0 1 0",
                      cyc, resp_sum, resp_pos_ovfl, resp_neg_ovfl, resp_ovfl, resp_cout);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_narrow_add();
    test_wide_sub();
    test_round_robin();
    test_wide_edges();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
